// File: rtl/serial_receive_pkg.sv
// Shared constants and types for the serial work-unit receiver.
// Holds baud divisor helper, unit layout and UART RX state encoding.
package serial_receive_pkg;

  localparam int CLK_FREQ_DEF = 109000000;
  localparam int BAUD_DEF     = 115200;
  localparam int NBYTES       = 44;
  localparam int UNIT_BITS    = NBYTES * 8;
  localparam int MIDSTATE_MSB = 351;
  localparam int MIDSTATE_LSB = 96;
  localparam int DATA2_BITS   = 96;

  function automatic int calc_baud_div(
    input int clk_freq,
    input int baud
  );
    return clk_freq / baud;
  endfunction

  localparam int BAUD_DIV_DEF =
    calc_baud_div(CLK_FREQ_DEF, BAUD_DEF);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

endpackage

// File: rtl/serial_receive_uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser plus bit-level FSM.
// Ports: clk, reset, rxd in; byte_valid pulse and rx_byte out.
module uart_rx
  import serial_receive_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic       byte_valid,
  output logic [7:0] rx_byte
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

  logic [1:0] sync_q;
  logic       rxd_s;

  // Idle-high reset value avoids a false start bit.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rxd};
  end

  assign rxd_s = sync_q[1];

  rx_state_e       state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shreg_q;
  logic            valid_q;
  logic [7:0]      byte_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      valid_q <= 1'b0;
      byte_q  <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (!rxd_s) state_q <= RX_START;
        end
        RX_START: begin
          if (cnt_q == HALF) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            // High at mid-start means a glitch.
            state_q <= rxd_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == FULL) begin
            cnt_q   <= '0;
            shreg_q <= {rxd_s, shreg_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == FULL) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            // Framing error drops the byte silently.
            if (rxd_s) begin
              valid_q <= 1'b1;
              byte_q  <= shreg_q;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign byte_valid = valid_q;
  assign rx_byte    = byte_q;

endmodule

// File: rtl/serial_receive.sv
// Assembles 44 UART bytes into midstate/data2 work-unit outputs.
// Ports: clk, reset, RxD in; midstate, data2, rx_done out.
module serial_receive
  import serial_receive_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int BAUD     = BAUD_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         RxD,
  output logic [255:0] midstate,
  output logic [255:0] data2,
  output logic         rx_done
);

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
  localparam int TIMEOUT  = 16 * BAUD_DIV * 10;
  localparam int IW       = $clog2(TIMEOUT + 1);
  localparam int BW       = UNIT_BITS - 8;

  logic       byte_valid;
  logic [7:0] rx_byte;

  uart_rx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rxd        (RxD),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte)
  );

  logic [5:0]           count_q, count_d;
  logic [BW-1:0]        buf_q, buf_d;
  logic [IW-1:0]        idle_q, idle_d;
  logic [255:0]         mid_q, mid_d;
  logic [255:0]         d2_q, d2_d;
  logic                 done_q, done_d;
  logic [UNIT_BITS-1:0] unit;

  always_comb begin
    count_d = count_q;
    buf_d   = buf_q;
    idle_d  = idle_q;
    mid_d   = mid_q;
    d2_d    = d2_q;
    done_d  = 1'b0;
    // Last byte goes straight into the latch.
    unit    = {buf_q, rx_byte};
    if (byte_valid) begin
      idle_d = '0;
      buf_d  = {buf_q[BW-9:0], rx_byte};
      if (count_q == 6'(NBYTES - 1)) begin
        count_d = '0;
        mid_d   = unit[MIDSTATE_MSB:MIDSTATE_LSB];
        d2_d    = {{(256 - DATA2_BITS){1'b0}},
                   unit[DATA2_BITS-1:0]};
        done_d  = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else begin
      if (idle_q != IW'(TIMEOUT)) idle_d = idle_q + 1'b1;
      if (count_q != '0 && idle_q == IW'(TIMEOUT))
        count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      buf_q   <= '0;
      idle_q  <= '0;
      mid_q   <= '0;
      d2_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      buf_q   <= buf_d;
      idle_q  <= idle_d;
      mid_q   <= mid_d;
      d2_q    <= d2_d;
      done_q  <= done_d;
    end
  end

  assign midstate = mid_q;
  assign data2    = d2_q;
  assign rx_done  = done_q;

endmodule

// File: tb/tb_serial_receive.sv
// Scoreboard bench for serial_receive at a reduced clock rate.
// Byte-level model predicts units; monitor checks each rx_done.
module tb_serial_receive;

  localparam int CLK_FREQ = 921600;
  localparam int BAUD     = 115200;
  localparam int DIV      = CLK_FREQ / BAUD;
  localparam int TIMEOUT  = 16 * DIV * 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         RxD = 1'b1;
  logic [255:0] midstate;
  logic [255:0] data2;
  logic         rx_done;

  serial_receive #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .RxD      (RxD),
    .midstate (midstate),
    .data2    (data2),
    .rx_done  (rx_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] m;
    logic [255:0] d;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] pend[$];
  logic [7:0] cur[44];
  int         n_checks = 0;
  int         n_err = 0;

  task automatic check(
    input string        nm,
    input logic [255:0] act,
    input logic [255:0] req
  );
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // Reference: first accepted byte is the unit's MSB byte.
  task automatic model_byte(input logic [7:0] b);
    exp_t e;
    pend.push_back(b);
    if (pend.size() == 44) begin
      e.m = '0;
      e.d = '0;
      for (int i = 0; i < 32; i++)
        e.m[255 - 8*i -: 8] = pend[i];
      for (int i = 32; i < 44; i++)
        e.d[95 - 8*(i-32) -: 8] = pend[i];
      exp_q.push_back(e);
      pend.delete();
    end
  endtask

  task automatic send_byte(
    input logic [7:0] b,
    input bit         bad
  );
    RxD = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (DIV) @(negedge clk);
    end
    if (!bad) model_byte(b);
    RxD = !bad;
    repeat (DIV) @(negedge clk);
    if (bad) begin
      RxD = 1'b1;
      repeat (2 * DIV) @(negedge clk);
    end
  endtask

  task automatic gap(input int n);
    RxD = 1'b1;
    repeat (n) @(negedge clk);
    if (n > TIMEOUT + 4 * DIV) pend.delete();
  endtask

  task automatic fill_seq();
    for (int i = 0; i < 44; i++) cur[i] = 8'(i);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 44; i++)
      cur[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic send_cur(input int from, input int to);
    for (int i = from; i < to; i++) send_byte(cur[i], 1'b0);
  endtask

  // Monitor: pops an expectation on every rx_done.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rx_done) begin
        if (prev) begin
          n_checks++;
          n_err++;
          $display("FAIL done_width: got 2+ cycles want 1");
        end
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL spurious_done: got 1 want 0");
        end else begin
          e = exp_q.pop_front();
          check("midstate", midstate, e.m);
          check("data2", data2, e.d);
        end
      end
      prev = rx_done;
    end
  end

  logic [255:0] d2_seq;

  initial begin
    d2_seq = 256'h2021_2223_2425_2627_2829_2A2B;
    repeat (3) @(negedge clk);
    check("rst_mid", midstate, '0);
    check("rst_d2", data2, '0);
    check("rst_done", 256'(rx_done), '0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Partial unit then timeout; outputs stay at 0.
    fill_seq();
    send_cur(0, 20);
    gap(TIMEOUT + 20 * DIV);
    check("partial_mid", midstate, '0);
    check("partial_d2", data2, '0);

    // Full sequential unit with known layout.
    send_cur(0, 44);
    gap(4 * DIV);
    check("seq_mid", midstate,
      256'h00010203_04050607_08090A0B_0C0D0E0F_10111213_14151617_18191A1B_1C1D1E1F);
    check("seq_d2", data2, d2_seq);

    // Framing error on byte 10, then an extra 0xFF.
    fill_rand();
    for (int i = 0; i < 44; i++)
      send_byte(cur[i], i == 10);
    send_byte(8'hFF, 1'b0);
    gap(4 * DIV);
    check("frame_lsb", 256'(data2[7:0]), 256'hFF);

    // Glitch inside a unit must not count as a byte.
    fill_rand();
    send_cur(0, 10);
    RxD = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    gap(5 * DIV);
    send_cur(10, 44);
    gap(2 * DIV);

    // Two random units back to back.
    fill_rand();
    send_cur(0, 44);
    fill_rand();
    send_cur(0, 44);
    gap(2 * DIV);

    // Reset mid-unit clears outputs.
    fill_rand();
    send_cur(0, 30);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    pend.delete();
    check("mid_rst_mid", midstate, '0);
    check("mid_rst_d2", data2, '0);
    fill_rand();
    send_cur(0, 44);
    gap(4 * DIV);

    check("queue_drained", 256'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors",
      n_checks, n_err);
    $finish;
  end

endmodule
